huffman_bit_packer: RTL

- Sits directly downstream of the Huffman code generator in the entropy coder.
- Consumes variable-length Huffman codes (1..CODE_W bits each) and packs them MSB-first into contiguous fixed-length CODE_W-bit words.
- Its output bus carries the same fields as the team's fixedLength_t (data, sop, eop, valid), plus a ready handshake.
- On end of frame it flushes residual bits, padding with 1s per JPEG, and pulses done. Byte stuffing (0xFF->0xFF00) is handled by the next stage.

---
 rtl/huffman_bit_packer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/huffman_bit_packer.sv
// ---------------------------------------------------------------------------
// huffman_bit_packer
//
// Packs variable-length Huffman codes (1..CODE_W bits, right-aligned on
// in_code) MSB-first into contiguous CODE_W-bit words. At end of frame the
// residual bits are flushed with 1-padding (JPEG convention) and done pulses
// once the last word has been taken. Byte stuffing happens downstream.
//
// Ports:
//   clk, rst              single rising-edge clock, synchronous active-high reset
//   in_code/in_size       code bits (low in_size bits valid) and bit count
//   in_sop/in_eop         first / last code of a frame
//   in_valid/in_ready     input handshake (in_ready is registered-state only)
//   out_data              packed word, first emitted bit in the MSB
//   out_sop/out_eop       first / last word of a frame
//   out_valid/out_ready   output handshake, word held while stalled
//   done                  one-cycle pulse after the eop word is accepted
// ---------------------------------------------------------------------------
module huffman_bit_packer #(
    parameter  int CODE_W = 64,
    localparam int SIZE_W = $clog2(CODE_W) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] in_code,
    input  logic [SIZE_W-1:0] in_size,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [CODE_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done
);

    localparam int ACC_W = 2 * CODE_W;
    localparam int CNT_W = SIZE_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(CODE_W);
    localparam logic [SIZE_W-1:0] MAX_SIZE = SIZE_W'(CODE_W);

    typedef enum logic [1:0] {
        PACK,
        FLUSH,
        DONE
    } state_t;

    state_t            state;
    logic [ACC_W-1:0]  acc;       // MSB-aligned bit accumulator
    logic [CNT_W-1:0]  cnt;       // number of valid bits in acc
    logic              sop_pend;  // next emitted word carries out_sop
    logic              eop_sent;  // eop word is in the output register
    logic              live;      // holds in_ready low for the first cycle out of reset

    logic              accept;
    logic              out_free;
    logic [SIZE_W-1:0] size_sat;
    logic [CODE_W-1:0] code_mask;
    logic [ACC_W-1:0]  base_acc;
    logic [ACC_W-1:0]  code_ext;
    logic [ACC_W-1:0]  ins_acc;
    logic [CNT_W-1:0]  base_cnt;
    logic [CNT_W-1:0]  ins_cnt;
    logic [CODE_W-1:0] top_word;
    logic [ACC_W-1:0]  acc_shifted;

    assign in_ready    = live && (state == PACK) && (cnt < FULL_CNT);
    assign accept      = in_valid && in_ready;
    assign out_free    = !out_valid || out_ready;
    assign top_word    = acc[ACC_W-1 -: CODE_W];
    assign acc_shifted = {acc[CODE_W-1:0], {CODE_W{1'b0}}};

    // Insertion of an accepted code at bit position cnt. A sop beat restarts
    // the frame, so any residual bits are discarded before insertion.
    // The code is placed in the upper half, shifted up so its MSB lands at
    // the top of the accumulator, then shifted down by the fill level.
    always_comb begin
        size_sat  = (in_size > MAX_SIZE) ? MAX_SIZE : in_size;
        code_mask = ~({CODE_W{1'b1}} << size_sat);
        base_acc  = in_sop ? '0 : acc;
        base_cnt  = in_sop ? '0 : cnt;
        code_ext  = {in_code & code_mask, {CODE_W{1'b0}}};
        ins_acc   = base_acc | ((code_ext << (MAX_SIZE - size_sat)) >> base_cnt);
        ins_cnt   = base_cnt + {1'b0, size_sat};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PACK;
            acc       <= '0;
            cnt       <= '0;
            sop_pend  <= 1'b0;
            eop_sent  <= 1'b0;
            live      <= 1'b0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            live <= 1'b1;
            done <= 1'b0;

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_sop   <= 1'b0;
                out_eop   <= 1'b0;
            end

            case (state)
                PACK: begin
                    // in_ready requires cnt < CODE_W, so accepting and
                    // emitting never happen in the same cycle.
                    if (accept) begin
                        acc <= ins_acc;
                        cnt <= ins_cnt;
                        if (in_sop) sop_pend <= 1'b1;
                        if (in_eop) state <= FLUSH;
                    end else if ((cnt >= FULL_CNT) && out_free) begin
                        out_data  <= top_word;
                        out_sop   <= sop_pend;
                        out_eop   <= 1'b0;
                        out_valid <= 1'b1;
                        sop_pend  <= 1'b0;
                        acc       <= acc_shifted;
                        cnt       <= cnt - FULL_CNT;
                    end
                end

                FLUSH: begin
                    if (eop_sent) begin
                        if (out_valid && out_ready) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            eop_sent <= 1'b0;
                        end
                    end else if (out_free) begin
                        out_sop   <= sop_pend;
                        out_valid <= 1'b1;
                        sop_pend  <= 1'b0;
                        if (cnt > FULL_CNT) begin
                            out_data <= top_word;
                            out_eop  <= 1'b0;
                            acc      <= acc_shifted;
                            cnt      <= cnt - FULL_CNT;
                        end else begin
                            // Last word: bits below the residual are zero in
                            // acc, so OR-ing ones pads them. cnt == CODE_W
                            // gives a zero pad mask; cnt == 0 an all-ones word.
                            out_data <= top_word | ({CODE_W{1'b1}} >> cnt);
                            out_eop  <= 1'b1;
                            acc      <= '0;
                            cnt      <= '0;
                            eop_sent <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    state <= PACK;
                end

                default: begin
                    state <= PACK;
                end
            endcase
        end
    end

endmodule
